nanorv32_alu_wb: RTL and testbench
==================================

// Module: nanorv32_alu_wb
// PURPOSE
//  Writeback stage directly downstream of the ALU/mul/div execute block.
//  - Captures the ALU result (alu_res) and destination register index; arbitrates
//    the single register-file write port against load writeback.
//  - Stalls execute while a divide is in flight.
//  - Holds a displaced ALU result in a one-entry skid buffer.
//  - Counts divide stall cycles.
// PARAMETERS
//  DATA_W  32  datapath width, equal to NANORV32_DATA_MSB+1
//  REG_AW  5   register index width
//  CNT_W   16  width of the divide stall counter
// PORTS
//  clk           in   1       core clock
//  rst_n         in   1       asynchronous active-low reset
//  ex_valid      in   1       execute presents an instruction with a register result
//  ex_rd         in   REG_AW  destination register index
//  ex_res        in   DATA_W  ALU result (alu_res)
//  ex_is_div     in   1       instruction is DIV/DIVU/REM/REMU
//  div_ready     in   1       divider result valid (from ALU div_ready)
//  ex_ready      out  1       writeback accepts ex_* this cycle
//  ld_wr_req     in   1       load unit writes the register file (highest priority)
//  ld_rd         in   REG_AW  load destination index
//  ld_data       in   DATA_W  load data
//  flush         in   1       pipeline flush (branch/trap)
//  rf_wr_en      out  1       register-file write enable (registered)
//  rf_wr_addr    out  REG_AW  register-file write index (registered)
//  rf_wr_data    out  DATA_W  register-file write data (registered)
//  fwd_valid     out  1       forwarding entry valid
//  fwd_rd        out  REG_AW  forwarding index
//  fwd_data      out  DATA_W  forwarding data
//  div_stall_cnt out  CNT_W   saturating count of divide stall cycles
// BEHAVIOUR
//  - Reset: all outputs 0; skid empty; counter 0. ex_ready is combinational (see below).
//  - Skid states: EMPTY and FULL.
//  - ex_ready = (skid EMPTY) & (~ex_is_div | div_ready).
//    Accept when ex_valid & ex_ready & ~flush.
//  - Write selection at each clock edge, in priority order; the registered rf_wr_*
//    are updated at that edge:
//    1. ld_wr_req -> write the load.
//    2. else skid FULL -> write the skid contents; skid -> EMPTY.
//    3. else accept -> write ex_res.
//    4. else rf_wr_en=0; rf_wr_addr/data hold their previous values.
//  - Accept and ld_wr_req in the same cycle: ALU result goes to the skid (FULL).
//    It is written on the first later edge with ld_wr_req=0.
//  - Latency: accept at edge N -> rf_wr_en=1 in cycle N+1 (no load conflict).
//  - Index 0: any write with rd==0 is dropped; rf_wr_en stays 0 and the skid is not filled.
//  - Skid FULL plus further loads: skid holds indefinitely; ex_ready=0; no loss.
//  - flush: blocks acceptance that cycle and clears the skid (FULL->EMPTY, result dropped).
//    Load writes are never flushed. A flush does not cancel rf_wr_en already registered.
//  - div_stall_cnt: +1 on each cycle with ex_valid & ex_is_div & ~div_ready & ~flush.
//    Saturates at all-ones; cleared only by reset.
//  - Reset mid-operation: skid contents and a pending write are discarded immediately
//    (asynchronous); no rf write is issued after reset release.
// CONFIGURATION
//  NANORV32_WB_FWD_EN defined:
//   - fwd_valid/fwd_rd/fwd_data mirror the write registered at the last edge
//     (rf_wr_en/addr/data).
//   - When skid FULL and rf_wr_en=0, they present the skid entry instead.
//  NANORV32_WB_FWD_EN undefined: fwd_valid, fwd_rd and fwd_data are tied to 0;
//   no forwarding logic is synthesised.
// TESTING
//  1. ex_valid=1, ex_rd=5, ex_res=32'h1234_5678, ex_is_div=0
//     -> next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=32'h1234_5678.
//  2. Same cycle: accept rd=3, res=32'hA; ld_wr_req rd=7, data=32'hB
//     -> cycle+1 writes r7=32'hB and ex_ready=0; cycle+2 writes r3=32'hA.
//  3. ex_is_div=1, div_ready=0 for 10 cycles, then 1 with ex_res=32'd7, rd=9
//     -> ex_ready=0 for 10 cycles; div_stall_cnt=10; r9=7 written one cycle after div_ready.
//  4. ex_rd=0, ex_res=32'hFFFF_FFFF accepted -> rf_wr_en stays 0; skid unaffected.
//  5. Skid FULL (rd=4), then flush=1 -> skid cleared; r4 never written; ex_ready=1 next cycle.
//  6. Stall with CNT_W=4 for 20 cycles -> div_stall_cnt saturates at 15.
//     Assert rst_n=0 while skid FULL -> all outputs 0 immediately; no write after release.
//  7. With NANORV32_WB_FWD_EN: fwd_* equal rf_wr_* in cycle N+1 of scenario 1.
//     Without it: fwd_valid is 0 throughout.

Source files
------------

// File: rtl/nanorv32_alu_wb.sv
// nanorv32_alu_wb -- writeback stage after the ALU/mul/div execute block.
//
// Owns the single register-file write port. Load writeback has priority.
// When a load and an ALU result collide, the ALU result is parked in a
// one-entry skid buffer and drained on the next load-free edge. Execute is
// stalled while a divide is in flight, and the number of stalled divide
// cycles is counted in a saturating counter.
//
// Optional feature macro: NANORV32_WB_FWD_EN
//   When defined, the fwd_* outputs expose the most recently registered write.
//   If no write was registered and the skid is full, they expose the skid entry.
//   When undefined, the fwd_* outputs are tied to 0.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_valid/ex_rd/ex_res          execute result and destination index
//   ex_is_div/div_ready            divide in flight / divider result valid
//   ex_ready                       combinational accept back to execute
//   ld_wr_req/ld_rd/ld_data        load writeback request (highest priority)
//   flush                          blocks acceptance and drops the skid entry
//   rf_wr_en/rf_wr_addr/rf_wr_data registered register-file write
//   fwd_valid/fwd_rd/fwd_data      forwarding view of the pending result
//   div_stall_cnt                  saturating divide stall cycle count

module nanorv32_alu_wb #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_res,
  input  logic              ex_is_div,
  input  logic              div_ready,
  output logic              ex_ready,
  input  logic              ld_wr_req,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              flush,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  div_stall_cnt
);

  typedef enum logic {SKID_EMPTY = 1'b0, SKID_FULL = 1'b1} skid_t;

  skid_t             skid_st;
  logic [REG_AW-1:0] skid_rd;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              ex_wr;
  logic              div_stall;

  assign ex_ready  = (skid_st == SKID_EMPTY) & (~ex_is_div | div_ready);
  assign accept    = ex_valid & ex_ready & ~flush;
  // r0 is hardwired to zero, so a result aimed at it is discarded outright
  // and never occupies the skid.
  assign ex_wr     = accept & (ex_rd != '0);
  assign div_stall = ex_valid & ex_is_div & ~div_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_st    <= SKID_EMPTY;
      skid_rd    <= '0;
      skid_data  <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      if (ld_wr_req) begin
        // The load owns the port even when it targets r0; the write is dropped.
        if (ld_rd != '0) begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= ld_rd;
          rf_wr_data <= ld_data;
        end
        // accept implies the skid is empty, so it can be filled here.
        if (flush) begin
          skid_st <= SKID_EMPTY;
        end else if (ex_wr) begin
          skid_st   <= SKID_FULL;
          skid_rd   <= ex_rd;
          skid_data <= ex_res;
        end
      end else if (skid_st == SKID_FULL) begin
        skid_st <= SKID_EMPTY;
        // A flush drops the parked result instead of writing it.
        if (!flush) begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= skid_rd;
          rf_wr_data <= skid_data;
        end
      end else if (ex_wr) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= ex_rd;
        rf_wr_data <= ex_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_stall_cnt <= '0;
    else if (div_stall && (div_stall_cnt != '1))
      div_stall_cnt <= div_stall_cnt + 1'b1;
  end

`ifdef NANORV32_WB_FWD_EN
  always_comb begin
    fwd_valid = rf_wr_en;
    fwd_rd    = rf_wr_addr;
    fwd_data  = rf_wr_data;
    if (!rf_wr_en && (skid_st == SKID_FULL)) begin
      fwd_valid = 1'b1;
      fwd_rd    = skid_rd;
      fwd_data  = skid_data;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_nanorv32_alu_wb.sv
// Directed testbench for nanorv32_alu_wb. A table of per-cycle vectors
// (inputs, expected ex_ready before the edge, expected outputs after it)
// is applied in sequence. Hand-written sequences follow for counter
// saturation and an asynchronous reset while the skid is full.
module tb_nanorv32_alu_wb;
  localparam int DW = 32, AW = 5, CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_is_div, div_ready, ld_wr_req, flush;
  logic [AW-1:0] ex_rd, ld_rd;
  logic [DW-1:0] ex_res, ld_data;
  logic          ex_ready, rf_wr_en, fwd_valid;
  logic [AW-1:0] rf_wr_addr, fwd_rd;
  logic [DW-1:0] rf_wr_data, fwd_data;
  logic [CW-1:0] div_stall_cnt;

  nanorv32_alu_wb #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_res(ex_res),
    .ex_is_div(ex_is_div), .div_ready(div_ready), .ex_ready(ex_ready),
    .ld_wr_req(ld_wr_req), .ld_rd(ld_rd), .ld_data(ld_data), .flush(flush),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .div_stall_cnt(div_stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [AW-1:0] rd; logic [DW-1:0] res; logic div, dr;
    logic ld; logic [AW-1:0] lrd; logic [DW-1:0] ldat; logic fl;
    logic e_rdy, e_en; logic [AW-1:0] e_addr; logic [DW-1:0] e_data; logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic v, logic [AW-1:0] rd, logic [DW-1:0] res, logic div,
                              logic dr, logic ld, logic [AW-1:0] lrd, logic [DW-1:0] ldat,
                              logic fl, logic e_rdy, logic e_en, logic [AW-1:0] e_addr,
                              logic [DW-1:0] e_data, logic [CW-1:0] e_cnt);
    vec_t t;
    t.v = v; t.rd = rd; t.res = res; t.div = div; t.dr = dr; t.ld = ld; t.lrd = lrd;
    t.ldat = ldat; t.fl = fl; t.e_rdy = e_rdy; t.e_en = e_en; t.e_addr = e_addr;
    t.e_data = e_data; t.e_cnt = e_cnt;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ex_valid = t.v; ex_rd = t.rd; ex_res = t.res; ex_is_div = t.div; div_ready = t.dr;
    ld_wr_req = t.ld; ld_rd = t.lrd; ld_data = t.ldat; flush = t.fl;
  endtask

  task automatic idle();
    ex_valid = 0; ex_rd = '0; ex_res = '0; ex_is_div = 0; div_ready = 0;
    ld_wr_req = 0; ld_rd = '0; ld_data = '0; flush = 0;
  endtask

  task automatic chk_fwd(input string nm);
`ifdef NANORV32_WB_FWD_EN
    if (rf_wr_en) begin
      chk({nm, "_fwd_v"}, 64'(fwd_valid), 64'd1);
      chk({nm, "_fwd_rd"}, 64'(fwd_rd), 64'(rf_wr_addr));
      chk({nm, "_fwd_d"}, 64'(fwd_data), 64'(rf_wr_data));
    end
`else
    chk({nm, "_fwd_v"}, 64'(fwd_valid), 64'd0);
`endif
  endtask

  initial begin
    // v rd res div dr ld lrd ldat fl | rdy en addr data cnt
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0);
    add(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 1, 1, 5, 32'h1234_5678, 0);
    add(1, 3, 32'hA, 0, 0, 1, 7, 32'hB, 0,     1, 1, 7, 32'hB, 0);   // collision -> skid
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 1, 3, 32'hA, 0);   // skid drains
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 3, 32'hA, 0);
    add(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1, 0, 3, 32'hA, 0);   // r0 dropped
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 3, 32'hA, 0);
    add(1, 4, 32'h44, 0, 0, 1, 8, 32'h88, 0,   1, 1, 8, 32'h88, 0);  // skid holds r4
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,             0, 0, 8, 32'h88, 0);  // flush drops r4
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 8, 32'h88, 0);
    add(1, 10, 32'hAA, 0, 0, 1, 11, 32'hBB, 0, 1, 1, 11, 32'hBB, 0);
    add(1, 13, 32'hDD, 0, 0, 1, 12, 32'hCC, 0, 0, 1, 12, 32'hCC, 0); // skid persists
    add(1, 13, 32'hDD, 0, 0, 0, 0, 0, 0,       0, 1, 10, 32'hAA, 0);
    add(1, 13, 32'hDD, 0, 0, 0, 0, 0, 0,       1, 1, 13, 32'hDD, 0);
    add(0, 0, 0, 0, 0, 1, 0, 32'h55, 0,        1, 0, 13, 32'hDD, 0); // load to r0
    add(1, 14, 32'hEE, 0, 0, 0, 0, 0, 1,       1, 0, 13, 32'hDD, 0); // flush blocks
    for (int k = 1; k <= 10; k++)
      add(1, 9, 0, 1, 0, 0, 0, 0, 0,           0, 0, 13, 32'hDD, 4'(k));
    add(1, 9, 32'd7, 1, 1, 0, 0, 0, 0,         1, 1, 9, 32'd7, 10);
    add(1, 9, 0, 1, 0, 0, 0, 0, 1,             0, 0, 9, 32'd7, 10);  // flushed stall not counted
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 9, 32'd7, 10);

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 64'(rf_wr_en), 0);
    chk("rst_addr", 64'(rf_wr_addr), 0);
    chk("rst_data", 64'(rf_wr_data), 0);
    chk("rst_cnt", 64'(div_stall_cnt), 0);
    chk("rst_fwd_v", 64'(fwd_valid), 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < vq.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk({nm, "_rdy"}, 64'(ex_ready), 64'(vq[i].e_rdy));
      @(posedge clk);
      #1;
      chk({nm, "_en"}, 64'(rf_wr_en), 64'(vq[i].e_en));
      chk({nm, "_addr"}, 64'(rf_wr_addr), 64'(vq[i].e_addr));
      chk({nm, "_data"}, 64'(rf_wr_data), 64'(vq[i].e_data));
      chk({nm, "_cnt"}, 64'(div_stall_cnt), 64'(vq[i].e_cnt));
      chk_fwd(nm);
    end

    // Counter saturation: 20 more stall cycles from 10 must stop at 15.
    @(negedge clk);
    idle();
    ex_valid = 1; ex_is_div = 1; ex_rd = 5'd2;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_cnt", 64'(div_stall_cnt), 64'd15);
    chk("sat_rdy", 64'(ex_ready), 0);
    chk("sat_en", 64'(rf_wr_en), 0);

    // Fill the skid, then assert reset asynchronously mid-cycle.
    @(negedge clk);
    idle();
    ex_valid = 1; ex_rd = 5'd6; ex_res = 32'h66; ld_wr_req = 1; ld_rd = 5'd7; ld_data = 32'h77;
    @(posedge clk);
    #1;
    chk("pre_rst_en", 64'(rf_wr_en), 1);
    chk("pre_rst_addr", 64'(rf_wr_addr), 7);
    @(negedge clk);
    idle();
    #1;
    chk("pre_rst_rdy", 64'(ex_ready), 0);
    #1;
    rst_n = 0;
    #1;
    chk("arst_en", 64'(rf_wr_en), 0);
    chk("arst_addr", 64'(rf_wr_addr), 0);
    chk("arst_data", 64'(rf_wr_data), 0);
    chk("arst_cnt", 64'(div_stall_cnt), 0);
    chk("arst_rdy", 64'(ex_ready), 1);
    chk("arst_fwd_v", 64'(fwd_valid), 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_en%0d", k), 64'(rf_wr_en), 0);
      chk($sformatf("post_rst_rdy%0d", k), 64'(ex_ready), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
